// File: rtl/div_hilo_ctrl.sv
// HI/LO issue/retire controller around the 32-cycle signed divider: DIVU fixups, divide-by-zero bypass.
// Optional build macro DIV_ZERO_FLAG_EN adds a dz_flag output pulsed with done on a zero divisor.
module div_hilo_ctrl #(
    parameter logic [31:0] DZ_LO = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        ctrl_busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_busy
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic        dz_flag
`endif
);

    // state  | meaning
    // IDLE   | waiting for req
    // LAUNCH | operands stable, div_start pulsed
    // WAIT   | divider running; capture q/r when it drops busy
    // FIXUP  | one restoring step for DIVU with dividend bit 31 set
    // WRITE  | commit q/r to LO/HI, pulse done
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FIXUP,
        S_WRITE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] q_r, r_r;
    logic        pre_r, a_lsb;
    logic        dz_case, big_case, pre_case, big_q;
    logic [31:0] big_r;
    logic [32:0] r2;
    logic        c_bit;
    logic [31:0] r_fix;

    assign dz_case  = (op_b == 32'd0);
    assign big_case = !is_signed && op_b[31];
    assign pre_case = !is_signed && op_a[31];
    assign big_q    = (op_a >= op_b);
    assign big_r    = big_q ? (op_a - op_b) : op_a;

    // r1 < b, so r2 < 2b and the 32-bit difference cannot wrap.
    assign r2    = {r_r, a_lsb};
    assign c_bit = (r2 >= {1'b0, div_divisor});
    assign r_fix = c_bit ? (r2[31:0] - div_divisor) : r2[31:0];

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:   if (req) state_nxt = (dz_case || big_case) ? S_WRITE : S_LAUNCH;
            S_LAUNCH: begin
                div_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT:   if (!div_busy) state_nxt = pre_r ? S_FIXUP : S_WRITE;
            S_FIXUP:  state_nxt = S_WRITE;
            S_WRITE:  begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_busy    <= 1'b0;
            hi           <= 32'd0;
            lo           <= 32'd0;
            div_dividend <= 32'd0;
            div_divisor  <= 32'd0;
            q_r          <= 32'd0;
            r_r          <= 32'd0;
            pre_r        <= 1'b0;
            a_lsb        <= 1'b0;
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            case (state)
                S_IDLE: if (req) begin
                    ctrl_busy    <= 1'b1;
                    pre_r        <= pre_case;
                    a_lsb        <= op_a[0];
                    div_divisor  <= op_b;
                    div_dividend <= pre_case ? {1'b0, op_a[31:1]} : op_a;
                    q_r          <= dz_case ? DZ_LO : {31'd0, big_q};
                    r_r          <= dz_case ? op_a : big_r;
                end
                S_WAIT: if (!div_busy) begin
                    q_r <= div_q;
                    r_r <= div_r;
                end
                S_FIXUP: begin
                    q_r <= {q_r[30:0], c_bit};
                    r_r <= r_fix;
                end
                // Result beats a coincident MTHI/MTLO.
                S_WRITE: begin
                    lo        <= q_r;
                    hi        <= r_r;
                    ctrl_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    logic dz_r;

    always_ff @(posedge clock) begin
        if (reset)                     dz_r <= 1'b0;
        else if (state == S_IDLE && req) dz_r <= dz_case;
    end

    assign dz_flag = done && dz_r;
`endif

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl: behavioural divider + HI/LO model, per-cycle compare, directed and random ops.
module tb_div_hilo_ctrl;
    localparam logic [31:0] DZ_LO = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, is_signed = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, wdata = '0;
    logic        ctrl_busy, done, div_start, div_busy;
    logic [31:0] hi, lo, div_dividend, div_divisor, div_q, div_r;
`ifdef DIV_ZERO_FLAG_EN
    logic        dz_flag;
`endif

    int errors = 0;
    int checks = 0;

    div_hilo_ctrl #(.DZ_LO(DZ_LO)) dut (
        .clock(clock), .reset(reset), .req(req), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .ctrl_busy(ctrl_busy), .done(done), .hi(hi), .lo(lo),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_q(div_q), .div_r(div_r), .div_busy(div_busy)
`ifdef DIV_ZERO_FLAG_EN
        , .dz_flag(dz_flag)
`endif
    );

    always #5 clock = ~clock;

    // Divider: signed truncating division on its operands, busy for 32 cycles after start.
    function automatic logic [63:0] sdiv(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, qq, rr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sy == 0) return 64'd0;
        qq = sx / sy;
        rr = sx % sy;
        return {qq[31:0], rr[31:0]};
    endfunction

    int dv_cnt = 0;
    assign {div_q, div_r} = sdiv(div_dividend, div_divisor);
    assign div_busy = (dv_cnt != 0);
    always @(posedge clock) begin
        if (reset)          dv_cnt <= 0;
        else if (div_start) dv_cnt <= 32;
        else if (dv_cnt != 0) dv_cnt <= dv_cnt - 1;
    end

    // Architectural result of one operation plus its req->done latency in cycles.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output int lat,
                           output bit byp, output logic [31:0] dvd);
        longint la, lb;
        byp = 1'b0;
        dvd = (!s && a[31]) ? (a >> 1) : a;
        if (b == 32'd0) begin
            q = DZ_LO; r = a; lat = 1; byp = 1'b1;
        end else if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            q = 32'(la / lb);
            r = 32'(la % lb);
            lat = 35;
        end else begin
            q = a / b;
            r = a % b;
            byp = b[31];
            lat = b[31] ? 1 : (a[31] ? 36 : 35);
        end
    endtask

    // Model state: k = cycles since acceptance (0 = idle).
    logic [31:0] m_hi = '0, m_lo = '0, m_q = '0, m_r = '0, m_dvd = '0, m_dvs = '0;
    int          m_k = 0, m_lat = 0;
    bit          m_byp = 1'b0, m_dz = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_k = 0;
        end else begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (m_k != 0) begin
                if (m_k == m_lat) begin
                    m_hi = m_r; m_lo = m_q; m_k = 0;
                end else m_k++;
            end else if (req) begin
                ref_div(op_a, op_b, is_signed, m_q, m_r, m_lat, m_byp, m_dvd);
                m_dvs = op_b;
                m_dz  = (op_b == 32'd0);
                m_k   = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        bit e_done;
        e_done = (m_k != 0) && (m_k == m_lat);
        chk("ctrl_busy", 32'(ctrl_busy), 32'(m_k != 0));
        chk("done", 32'(done), 32'(e_done));
        chk("div_start", 32'(div_start), 32'((m_k == 1) && !m_byp));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (m_k != 0 && !m_byp) begin
            chk("div_dividend", div_dividend, m_dvd);
            chk("div_divisor", div_divisor, m_dvs);
        end
`ifdef DIV_ZERO_FLAG_EN
        chk("dz_flag", 32'(dz_flag), 32'(e_done && m_dz));
`endif
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        req = 1'b1; op_a = a; op_b = b; is_signed = s;
        step();
        req = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom);
    endtask

    // Directed op: literal expectations pin both the model and the DUT.
    task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [31:0] e_lo, input logic [31:0] e_hi,
                            input int e_lat, input bit lo_hit, input int ghost_at);
        logic [31:0] q, r, dvd;
        int lat, n;
        bit byp;
        ref_div(a, b, s, q, r, lat, byp, dvd);
        chk({nm, " model lo"}, q, e_lo);
        chk({nm, " model hi"}, r, e_hi);
        chk({nm, " model latency"}, 32'(lat), 32'(e_lat));
        issue(a, b, s);
        n = 1;
        while (!done && n < 100) begin
            req = (n == ghost_at);
            if (n == ghost_at) begin op_a = 32'd1; op_b = 32'd1; is_signed = 1'b0; end
            step();
            n++;
        end
        req = 1'b0;
        chk({nm, " latency"}, 32'(n), 32'(e_lat));
`ifdef DIV_ZERO_FLAG_EN
        chk({nm, " dz_flag"}, 32'(dz_flag), 32'(b == 32'd0));
`endif
        if (lo_hit) begin lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
        step();
        lo_we = 1'b0;
        chk({nm, " lo"}, lo, e_lo);
        chk({nm, " hi"}, hi, e_hi);
    endtask

    task automatic random_ops(input int n_ops);
        logic [31:0] a, b;
        logic s;
        int g;
        for (int i = 0; i < n_ops; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom);
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin s = 1'b0; b = b | 32'h8000_0000; end
                2: begin s = 1'b0; a = a | 32'h8000_0000; b = $urandom_range(1, 1000); end
                3: begin s = 1'b1; b = $urandom_range(1, 70000); if ($urandom_range(0, 1) == 1) b = -b; end
                4: begin s = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: if (b == 32'd0) b = 32'd7;
            endcase
            issue(a, b, s);
            g = 0;
            while (ctrl_busy && g < 100) begin
                hi_we = ($urandom_range(0, 9) == 0);
                lo_we = ($urandom_range(0, 9) == 0);
                wdata = $urandom;
                req   = ($urandom_range(0, 15) == 0);
                op_a  = $urandom; op_b = $urandom;
                step();
                g++;
            end
            hi_we = 1'b0; lo_we = 1'b0; req = 1'b0;
            if (g >= 100) chk("random op timeout", 32'(g), 32'd0);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        chk("reset ctrl_busy", 32'(ctrl_busy), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        fork
            forever begin
                @(negedge clock);
                compare_cycle();
            end
        join_none

        directed("signed -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35, 1'b0, 0);
        directed("divu preshift", 32'hFFFF_FFFF, 32'd10, 1'b0, 32'h1999_9999, 32'd5, 36, 1'b0, 0);
        directed("divu big b", 32'h9000_0000, 32'h8000_0001, 1'b0, 32'd1, 32'h0FFF_FFFF, 1, 1'b0, 0);
        directed("div by zero", 32'h0000_1234, 32'd0, 1'b1, DZ_LO, 32'h0000_1234, 1, 1'b0, 0);
        directed("signed overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 35, 1'b0, 0);
        directed("ghost req", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 35, 1'b0, 6);
        directed("lo_we in WRITE", 32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 35, 1'b1, 0);

        hi_we = 1'b1; wdata = 32'hCAFE_0001;
        step();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hCAFE_0002;
        step();
        lo_we = 1'b0;
        chk("mthi idle", hi, 32'hCAFE_0001);
        chk("mtlo idle", lo, 32'hCAFE_0002);

        issue(32'd100, 32'd7, 1'b1);
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid reset ctrl_busy", 32'(ctrl_busy), 32'd0);
        chk("mid reset div_start", 32'(div_start), 32'd0);
        chk("mid reset hi", hi, 32'd0);
        chk("mid reset lo", lo, 32'd0);
        directed("after reset", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 35, 1'b0, 0);

        random_ops(40);
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
